// File: rtl/fft_stage_ctrl_if.sv
// fft_stage_ctrl_if
//   Bundle between the FFT stage sequencer and its neighbours (top-level FFT
//   FSM, ping-pong RAM interface, twiddle ROM, butterfly unit).
//   slave  : the sequencer side (fft_stage_ctrl).
//   master : the controlling side (top-level FSM / testbench).
//   Signals:
//     start        transform request pulse (to sequencer)
//     busy, done   transform status
//     stage        current stage index
//     bank_select  ping-pong bank select (0: write bank0 / read bank1)
//     read_en, rd_address1/2, tw_index   read side of a butterfly
//     wr_en, wr_address1/2               delayed write side of a butterfly
//   Optional (FFT_CTRL_INVERSE_EN): inverse (to sequencer), tw_conj (from it).
interface fft_stage_ctrl_if #(
    parameter int N = 32
);
    localparam int LOG2N = $clog2(N);
    localparam int AW    = LOG2N;
    localparam int SW    = $clog2(LOG2N) + 1;

    logic          start;
    logic          busy;
    logic          done;
    logic [SW-1:0] stage;
    logic          bank_select;
    logic          read_en;
    logic [AW-1:0] rd_address1;
    logic [AW-1:0] rd_address2;
    logic          wr_en;
    logic [AW-1:0] wr_address1;
    logic [AW-1:0] wr_address2;
    logic [AW-2:0] tw_index;
`ifdef FFT_CTRL_INVERSE_EN
    logic          inverse;
    logic          tw_conj;
`endif

    modport slave (
`ifdef FFT_CTRL_INVERSE_EN
        input  inverse,
        output tw_conj,
`endif
        input  start,
        output busy, done, stage, bank_select,
        output read_en, rd_address1, rd_address2, tw_index,
        output wr_en, wr_address1, wr_address2
    );

    modport master (
`ifdef FFT_CTRL_INVERSE_EN
        output inverse,
        input  tw_conj,
`endif
        output start,
        input  busy, done, stage, bank_select,
        input  read_en, rd_address1, rd_address2, tw_index,
        input  wr_en, wr_address1, wr_address2
    );
endinterface

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl
//   Radix-2 in-place FFT stage sequencer. After start it walks every
//   butterfly of every stage, issuing one read address pair + twiddle index
//   per cycle, and replays each pair as a write address pair after the
//   RAM + butterfly latency. The ping-pong bank select flips once per stage.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset
//     bus    fft_stage_ctrl_if.slave (start/busy/done/stage/bank_select,
//            read and write address strobes, twiddle index)
//   Optional feature macro: FFT_CTRL_INVERSE_EN
//     adds bus.inverse (latched on start) and bus.tw_conj (= latched inverse
//     while read_en is high) for inverse transforms.
module fft_stage_ctrl #(
    parameter int N             = 32,
    parameter int RAM_LATENCY   = 1,
    parameter int BF_LATENCY    = 3,
    parameter int address_width = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    fft_stage_ctrl_if.slave bus
);
    localparam int LOG2N    = $clog2(N);
    localparam int AW       = address_width;
    localparam int KW       = AW - 1;
    localparam int SW       = $clog2(LOG2N) + 1;
    localparam int WR_DELAY = RAM_LATENCY + BF_LATENCY;

    localparam logic [SW-1:0]       LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [KW-1:0]       K_LAST     = KW'(N / 2 - 1);
    // all delay-line slots except the output slot
    localparam logic [WR_DELAY-1:0] LOW_MASK   = {WR_DELAY{1'b1}} >> 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_SWAP  = 2'd3;

    logic [1:0]    r_state;
    logic [SW-1:0] r_stage;
    logic [KW-1:0] r_k;
    logic          r_bank;

    logic [WR_DELAY-1:0]         r_dl_vld;
    logic [WR_DELAY-1:0][AW-1:0] r_dl_a1;
    logic [WR_DELAY-1:0][AW-1:0] r_dl_a2;

    logic          w_read_en;
    logic          w_last_stage;
    logic          w_drain_done;
    logic [AW-1:0] w_span;
    logic [AW-1:0] w_kx;
    logic [AW-1:0] w_pos;
    logic [AW-1:0] w_rd1;
    logic [AW-1:0] w_rd2;
    logic [AW-1:0] w_tw;

    assign w_read_en    = (r_state == S_READ);
    assign w_last_stage = (r_stage == LAST_STAGE);
    // Only the output slot may still hold a write: that write issues this
    // cycle, so the stage is finished after it.
    assign w_drain_done = ~|(r_dl_vld & LOW_MASK);

    // Butterfly addressing: the top address is k with a 0 bit inserted at
    // bit position 'stage'; the bottom address has that bit set.
    always_comb begin
        w_span = AW'(1) << r_stage;
        w_kx   = AW'(r_k);
        w_pos  = w_kx & (w_span - AW'(1));
        w_rd1  = ((w_kx >> r_stage) << (r_stage + SW'(1))) + w_pos;
        w_rd2  = w_rd1 + w_span;
        w_tw   = w_pos << (LAST_STAGE - r_stage);
        if (!w_read_en) begin
            w_rd1 = '0;
            w_rd2 = '0;
            w_tw  = '0;
        end
    end

    // Sequencer FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_k     <= '0;
            r_bank  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_READ;
                        r_stage <= '0;
                        r_k     <= '0;
                    end
                end
                S_READ: begin
                    if (r_k == K_LAST) begin
                        r_state <= S_DRAIN;
                        r_k     <= '0;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_drain_done) r_state <= S_SWAP;
                end
                default: begin // S_SWAP
                    r_bank <= ~r_bank;
                    if (w_last_stage) begin
                        r_state <= S_IDLE;
                        r_stage <= '0;
                    end else begin
                        r_state <= S_READ;
                        r_stage <= r_stage + SW'(1);
                    end
                end
            endcase
        end
    end

    // Write delay line: replays each read pair WR_DELAY cycles later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dl_vld <= '0;
            r_dl_a1  <= '0;
            r_dl_a2  <= '0;
        end else begin
            for (int i = WR_DELAY - 1; i > 0; i--) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                r_dl_a1[i]  <= r_dl_a1[i-1];
                r_dl_a2[i]  <= r_dl_a2[i-1];
            end
            r_dl_vld[0] <= w_read_en;
            r_dl_a1[0]  <= w_rd1;
            r_dl_a2[0]  <= w_rd2;
        end
    end

`ifdef FFT_CTRL_INVERSE_EN
    logic r_inverse;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inverse <= 1'b0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_inverse <= bus.inverse;
        end
    end

    assign bus.tw_conj = w_read_en & r_inverse;
`endif

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_SWAP) && w_last_stage;
    assign bus.stage       = r_stage;
    assign bus.bank_select = r_bank;
    assign bus.read_en     = w_read_en;
    assign bus.rd_address1 = w_rd1;
    assign bus.rd_address2 = w_rd2;
    assign bus.tw_index    = w_tw[AW-2:0];
    assign bus.wr_en       = r_dl_vld[WR_DELAY-1];
    assign bus.wr_address1 = r_dl_a1[WR_DELAY-1];
    assign bus.wr_address2 = r_dl_a2[WR_DELAY-1];
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb_fft_stage_ctrl
//   Directed bench for fft_stage_ctrl at N=32, RAM_LATENCY=1, BF_LATENCY=3
//   (WR_DELAY=4, 21-cycle stages, done at cycle 105). Outputs are sampled on
//   the falling edge; cycle 0 is the cycle in which start is accepted.
module tb_fft_stage_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    fft_stage_ctrl_if #(.N(32)) bus ();

    fft_stage_ctrl #(
        .N(32), .RAM_LATENCY(1), .BF_LATENCY(3), .address_width(5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic bank);
        chk({tag, ".busy"},   32'(bus.busy), 0);
        chk({tag, ".done"},   32'(bus.done), 0);
        chk({tag, ".stage"},  32'(bus.stage), 0);
        chk({tag, ".bank"},   32'(bus.bank_select), 32'(bank));
        chk({tag, ".rd_en"},  32'(bus.read_en), 0);
        chk({tag, ".rd1"},    32'(bus.rd_address1), 0);
        chk({tag, ".rd2"},    32'(bus.rd_address2), 0);
        chk({tag, ".tw"},     32'(bus.tw_index), 0);
        chk({tag, ".wr_en"},  32'(bus.wr_en), 0);
        chk({tag, ".wr1"},    32'(bus.wr_address1), 0);
        chk({tag, ".wr2"},    32'(bus.wr_address2), 0);
    endtask

    // Hand-computed butterflies: {cycle, rd1, rd2, tw}
    //   stage0 k=3 -> cycle 4;  stage1 k=7 -> cycle 29
    //   stage2 k=5 -> cycle 48; stage4 k=15 -> cycle 100
    int vec [4][4] = '{'{4, 6, 7, 0}, '{29, 13, 15, 8}, '{48, 9, 13, 4}, '{100, 15, 31, 15}};

    // One transform. inj: cycle of an extra (ignored) start pulse, 0 = none.
    // rst_at: cycle at which reset is asserted, 0 = run to completion.
    // b0: bank_select value before the run.
    task automatic do_run(input int inj, input int rst_at, input logic b0);
        logic [7:0] h1 [0:127];
        logic [7:0] h2 [0:127];
        int   nrd, nwr, donec, s, off;
        logic e_rd, e_wr, e_busy, e_done, e_bank;
        int   e_stage;
        nrd = 0; nwr = 0; donec = 0;
        @(negedge clk);
        bus.start = 1'b1;
`ifdef FFT_CTRL_INVERSE_EN
        bus.inverse = 1'b1;
`endif
        @(posedge clk);
        for (int c = 1; c <= 106; c++) begin
            @(negedge clk);
            bus.start = (c == inj);
`ifdef FFT_CTRL_INVERSE_EN
            bus.inverse = ~bus.inverse;
            chk($sformatf("tw_conj@%0d", c), 32'(bus.tw_conj), 32'(bus.read_en));
`endif
            if (c <= 105) begin
                s       = (c - 1) / 21;
                off     = (c - 1) % 21 + 1;
                e_rd    = (off <= 16);
                e_wr    = (off >= 5) && (off <= 20);
                e_bank  = b0 ^ s[0];
                e_busy  = 1'b1;
                e_done  = (c == 105);
                e_stage = s;
            end else begin
                e_rd = 0; e_wr = 0; e_bank = ~b0; e_busy = 0; e_done = 0; e_stage = 0;
            end
            chk($sformatf("rd_en@%0d", c), 32'(bus.read_en), 32'(e_rd));
            chk($sformatf("wr_en@%0d", c), 32'(bus.wr_en), 32'(e_wr));
            chk($sformatf("bank@%0d", c),  32'(bus.bank_select), 32'(e_bank));
            chk($sformatf("busy@%0d", c),  32'(bus.busy), 32'(e_busy));
            chk($sformatf("done@%0d", c),  32'(bus.done), 32'(e_done));
            chk($sformatf("stage@%0d", c), 32'(bus.stage), 32'(e_stage));

            h1[c] = 8'(bus.rd_address1);
            h2[c] = 8'(bus.rd_address2);
            if (bus.wr_en && c > 4) begin
                chk($sformatf("wr1_replay@%0d", c), 32'(bus.wr_address1), 32'(h1[c-4]));
                chk($sformatf("wr2_replay@%0d", c), 32'(bus.wr_address2), 32'(h2[c-4]));
            end
            for (int v = 0; v < 4; v++) begin
                if (c == vec[v][0]) begin
                    chk($sformatf("rd1_vec@%0d", c), 32'(bus.rd_address1), 32'(vec[v][1]));
                    chk($sformatf("rd2_vec@%0d", c), 32'(bus.rd_address2), 32'(vec[v][2]));
                    chk($sformatf("tw_vec@%0d", c),  32'(bus.tw_index), 32'(vec[v][3]));
                end
                if (c == vec[v][0] + 4) begin
                    chk($sformatf("wr1_vec@%0d", c), 32'(bus.wr_address1), 32'(vec[v][1]));
                    chk($sformatf("wr2_vec@%0d", c), 32'(bus.wr_address2), 32'(vec[v][2]));
                end
            end
            if (bus.read_en) nrd++;
            if (bus.wr_en) nwr++;
            if (bus.done) donec = c;

            if (c == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk_idle($sformatf("midrst@%0d", c + 1), 1'b0);
                reset = 1'b0;
                @(negedge clk);
                chk_idle($sformatf("postrst@%0d", c + 2), 1'b0);
                return;
            end
        end
        chk("read_count", 32'(nrd), 80);
        chk("write_count", 32'(nwr), 80);
        chk("done_cycle", 32'(donec), 105);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.start = 1'b1;   // start during reset must be ignored
`ifdef FFT_CTRL_INVERSE_EN
        bus.inverse = 1'b0;
`endif
        repeat (3) begin
            @(negedge clk);
            chk_idle("reset", 1'b0);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk_idle("after_reset", 1'b0);

        do_run(40, 0, 1'b0);  // extra start while busy, full run
        do_run(0, 50, 1'b1);  // previous run left bank_select=1; reset mid-run
        do_run(0, 0, 1'b0);   // fresh run after reset

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
